// File: rtl/buf_pkg.sv
// buf_pkg
//   Shared types and helpers for dual_mode_buffer and ring_ptr.
//   - buf_mode_e : buffer ordering (FIFO queue / LIFO stack)
//   - ptr_w      : pointer width for a given depth
//   - cnt_w      : occupancy counter width for a given depth (holds 0..depth)
//   - ptr_inc    : pointer increment, wraps depth-1 -> 0
//   - ptr_dec    : pointer decrement, wraps 0 -> depth-1
package buf_pkg;

  typedef enum logic {
    BUF_FIFO = 1'b0,
    BUF_LIFO = 1'b1
  } buf_mode_e;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Depth need not be a power of two, so wrap explicitly instead of
  // relying on natural overflow of the pointer bits.
  function automatic int ptr_inc(input int p, input int depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

  function automatic int ptr_dec(input int p, input int depth);
    return (p == 0) ? depth - 1 : p - 1;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// ring_ptr
//   Wrapping pointer register over 0..DEPTH-1 with increment, decrement and
//   hold. Asserting inc and dec together holds the pointer.
// Ports
//   clk  in   clock, rising edge
//   rst  in   asynchronous reset, active-high (pointer -> 0)
//   inc  in   advance pointer by one (wraps DEPTH-1 -> 0)
//   dec  in   retreat pointer by one (wraps 0 -> DEPTH-1)
//   ptr  out  current pointer value
module ring_ptr
  import buf_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = ptr;
    if (inc && !dec) begin
      ptr_nxt = PW'(ptr_inc(int'(ptr), DEPTH));
    end else if (dec && !inc) begin
      ptr_nxt = PW'(ptr_dec(int'(ptr), DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/dual_mode_buffer.sv
// dual_mode_buffer
//   Storage buffer of DEPTH entries (any DEPTH >= 2), selectable at runtime as
//   FIFO (queue) or LIFO (stack). The ordering mode is captured only while the
//   buffer is empty. head is a registered copy of the post-edge front entry.
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active-high
//   entry         in   data to store
//   insert        in   store entry this cycle
//   pop           in   remove current head this cycle
//   mode          in   0 = FIFO, 1 = LIFO (sampled only while empty)
//   head          out  registered front (FIFO oldest / LIFO newest)
//   full          out  count == DEPTH
//   empty         out  count == 0
//   count         out  occupancy
//   almost_full   out  count >= AF_THRESH
//   almost_empty  out  count <= AE_THRESH
//   overflow      out  (DUAL_BUF_ERR_EN only) sticky: insert while full, no pop
//   underflow     out  (DUAL_BUF_ERR_EN only) sticky: pop while empty
// Configuration
//   DUAL_BUF_ERR_EN : when defined, adds the sticky overflow/underflow flags.
module dual_mode_buffer
  import buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 5,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     entry,
  input  logic                      insert,
  input  logic                      pop,
  input  logic                      mode,
  output logic [DATA_WIDTH-1:0]     head,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      almost_full,
  output logic                      almost_empty
`ifdef DUAL_BUF_ERR_EN
  ,
  output logic                      overflow,
  output logic                      underflow
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_prev;
  logic [PW-1:0]         waddr;
  logic [PW-1:0]         front_addr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  buf_mode_e             mode_q;
  buf_mode_e             mode_cur;
  logic                  is_empty;
  logic                  is_full;
  logic                  can_pop;
  logic                  do_ins;
  logic                  do_pop;
  logic                  do_both;
  logic                  wr_en;
  logic                  wr_inc;
  logic                  wr_dec;
  logic                  rd_inc;
  logic                  head_upd;

  ring_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_inc),
    .dec (wr_dec),
    .ptr (wr_ptr)
  );

  ring_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_inc),
    .dec (1'b0),
    .ptr (rd_ptr)
  );

  // Operation decode. While empty the incoming mode applies; it only matters
  // for an insert, which behaves the same in both modes.
  always_comb begin
    is_empty  = (count_q == '0);
    is_full   = (count_q == CW'(DEPTH));
    mode_cur  = is_empty ? buf_mode_e'(mode) : mode_q;
    can_pop   = pop && !is_empty;
    do_both   = insert && can_pop;
    do_ins    = insert && !can_pop && !is_full;
    do_pop    = can_pop && !insert;
    wr_en     = do_ins || do_both;
    wr_prev   = PW'(ptr_dec(int'(wr_ptr), DEPTH));
    // LIFO insert+pop overwrites the top of stack in place.
    waddr     = (do_both && mode_cur == BUF_LIFO) ? wr_prev : wr_ptr;
    wr_inc    = do_ins || (do_both && mode_cur == BUF_FIFO);
    wr_dec    = do_pop && mode_cur == BUF_LIFO;
    rd_inc    = can_pop && mode_cur == BUF_FIFO;
    head_upd  = wr_en || can_pop;
    count_nxt = count_q;
    if (do_ins) begin
      count_nxt = count_q + 1'b1;
    end else if (do_pop) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Post-edge front. If the front slot is the one being written this edge,
  // forward entry so head reflects the insert with one cycle of latency.
  always_comb begin
    if (mode_cur == BUF_FIFO) begin
      front_addr = rd_inc ? PW'(ptr_inc(int'(rd_ptr), DEPTH)) : rd_ptr;
    end else if (wr_dec) begin
      front_addr = PW'(ptr_dec(int'(wr_prev), DEPTH));
    end else if (do_ins) begin
      front_addr = wr_ptr;
    end else begin
      front_addr = wr_prev;
    end
    head_nxt = head;
    if (count_nxt != '0) begin
      head_nxt = (wr_en && front_addr == waddr) ? entry : mem[front_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      mode_q  <= BUF_FIFO;
      head    <= '0;
    end else begin
      count_q <= count_nxt;
      if (is_empty) begin
        mode_q <= buf_mode_e'(mode);
      end
      if (head_upd) begin
        head <= head_nxt;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= entry;
    end
  end

  assign count        = count_q;
  assign full         = is_full;
  assign empty        = is_empty;
  assign almost_full  = (int'(count_q) >= AF_THRESH);
  assign almost_empty = (int'(count_q) <= AE_THRESH);

`ifdef DUAL_BUF_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (insert && is_full && !pop) begin
        overflow <= 1'b1;
      end
      if (pop && is_empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dual_mode_buffer.sv
// tb_dual_mode_buffer
//   Directed stimulus for dual_mode_buffer (DATA_WIDTH=8, DEPTH=5) with a
//   queue-based reference model compared every negative edge, plus literal
//   expectations at key points of each scenario.
module tb_dual_mode_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AFT   = DEPTH - 1;
  localparam int AET   = 1;

  logic          clk;
  logic          rst;
  logic [DW-1:0] entry;
  logic          insert;
  logic          pop;
  logic          mode;
  logic [DW-1:0] head;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          almost_full;
  logic          almost_empty;
`ifdef DUAL_BUF_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  int n_vec;
  int n_err;

  dual_mode_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
    .clk          (clk),
    .rst          (rst),
    .entry        (entry),
    .insert       (insert),
    .pop          (pop),
    .mode         (mode),
    .head         (head),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef DUAL_BUF_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, front is q[0] (FIFO) or the last element (LIFO).
  logic [DW-1:0] q[$];
  bit            m_lifo;
  logic [DW-1:0] m_head;
  bit            m_ovf;
  bit            m_unf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_lifo = 1'b0;
      m_head = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      if (insert === 1'b1 && pop !== 1'b1 && q.size() == DEPTH) m_ovf = 1'b1;
      if (pop === 1'b1 && q.size() == 0) m_unf = 1'b1;
      if (q.size() == 0) m_lifo = (mode === 1'b1);
      if (insert === 1'b1 && pop === 1'b1 && q.size() > 0) begin
        if (m_lifo) q[q.size()-1] = entry;
        else begin
          void'(q.pop_front());
          q.push_back(entry);
        end
      end else if (insert === 1'b1) begin
        if (q.size() < DEPTH) q.push_back(entry);
      end else if (pop === 1'b1 && q.size() > 0) begin
        if (m_lifo) void'(q.pop_back());
        else void'(q.pop_front());
      end
      if (q.size() > 0) m_head = m_lifo ? q[q.size()-1] : q[0];
    end
  end

  always @(negedge clk) begin
    chk("head",         32'(head),         32'(m_head));
    chk("count",        32'(count),        32'(q.size()));
    chk("full",         32'(full),         32'(q.size() == DEPTH));
    chk("empty",        32'(empty),        32'(q.size() == 0));
    chk("almost_full",  32'(almost_full),  32'(q.size() >= AFT));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AET));
`ifdef DUAL_BUF_ERR_EN
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_unf));
`endif
  end

  // One clock of stimulus: inputs change on the falling edge, return 1 ns
  // after the rising edge so literal checks sample settled outputs.
  task automatic step(input logic i, input logic p, input logic [DW-1:0] e, input logic m);
    @(negedge clk);
    insert = i;
    pop    = p;
    entry  = e;
    mode   = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] vals [5];
    n_vec  = 0;
    n_err  = 0;
    // 1: reset with unknown controls
    rst    = 1'b1;
    insert = 1'bx;
    pop    = 1'bx;
    entry  = 'x;
    mode   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_head",  32'(head), 32'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ae",    32'(almost_empty), 32'd1);
    #2;
    rst    = 1'b0;
    insert = 1'b0;
    pop    = 1'b0;
    entry  = '0;

    // 2: FIFO fill and drain
    vals = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB};
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, vals[i], 1'b0);
    chk("fifo_full",  32'(full), 32'd1);
    chk("fifo_count", 32'(count), 32'd5);
    chk("fifo_head",  32'(head), 32'hFF);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("fifo_pop_head", 32'(head), 32'(vals[i]));
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fifo_drained_empty", 32'(empty), 32'd1);
    chk("fifo_drained_head",  32'(head), 32'hBB);

    // 3: LIFO
    step(1'b1, 1'b0, 8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b0, 8'h33, 1'b1);
    chk("lifo_head3", 32'(head), 32'h33);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("lifo_pop_head", 32'(head), 32'h22);
    step(1'b1, 1'b1, 8'h44, 1'b1);
    chk("lifo_rep_head",  32'(head), 32'h44);
    chk("lifo_rep_count", 32'(count), 32'd2);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("lifo_pop2_head", 32'(head), 32'h11);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("lifo_empty", 32'(empty), 32'd1);

    // 4: FIFO overflow attempts
    vals = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, vals[i], 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovf_head",  32'(head), 32'hAA);
    chk("ovf_count", 32'(count), 32'd5);
`ifdef DUAL_BUF_ERR_EN
    chk("ovf_flag", 32'(overflow), 32'd1);
`endif
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("ovf_pop_head", 32'(head), 32'(vals[i]));
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("unf_count", 32'(count), 32'd0);
`ifdef DUAL_BUF_ERR_EN
    chk("unf_flag", 32'(underflow), 32'd1);
`endif

    // 5: FIFO pointer wrap, then insert+pop while full
    step(1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b0, 8'h20, 1'b0);
    step(1'b1, 1'b0, 8'h30, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, vals[i], 1'b0);
    chk("wrap_full", 32'(full), 32'd1);
    chk("wrap_head", 32'(head), 32'hA1);
    step(1'b1, 1'b1, 8'hB6, 1'b0);
    chk("wrap_both_head",  32'(head), 32'hA2);
    chk("wrap_both_count", 32'(count), 32'd5);
    for (int i = 2; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("wrap_pop_head", 32'(head), 32'(vals[i]));
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("wrap_last_head", 32'(head), 32'hB6);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // 6: mode change while non-empty is ignored; reset mid-fill
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("mode_ign_head",  32'(head), 32'h02);
    chk("mode_ign_count", 32'(count), 32'd2);
    step(1'b1, 1'b0, 8'h04, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_head",  32'(head), 32'h00);
    insert = 1'b0;
    pop    = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("post_rst_head",  32'(head), 32'h5A);
    chk("post_rst_count", 32'(count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
